// File: rtl/out_stream_arbiter.sv
// out_stream_arbiter: packet-aware round-robin arbiter sharing one registered
// AXI-Stream output between two sources. A grant is held until tlast (or the
// optional burst limit), and switching to the waiting source costs no bubble.
module out_stream_arbiter #(
    parameter int DWIDTH    = 128,
    parameter int BURST_LEN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] s_axis_tdata_0,
    input  logic              s_axis_tvalid_0,
    input  logic              s_axis_tlast_0,
    output logic              s_axis_tready_0,
    input  logic [DWIDTH-1:0] s_axis_tdata_1,
    input  logic              s_axis_tvalid_1,
    input  logic              s_axis_tlast_1,
    output logic              s_axis_tready_1,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tid,
    input  logic              m_axis_tready,
    output logic              busy
);

    // Counter wide enough for BURST_LEN beats; one bit when the limit is disabled.
    localparam int CW    = (BURST_LEN == 0) ? 1 : $clog2(BURST_LEN + 1);
    localparam int LIM_I = (BURST_LEN == 0) ? 0 : BURST_LEN - 1;
    localparam logic [CW-1:0] LIM = CW'(LIM_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state_q;
    logic              rr_ptr_q;      // source holding priority on a tie
    logic [CW-1:0]     beat_cnt_q;    // beats accepted in the current grant
    logic [CW-1:0]     beat_cnt_d;
    logic [1:0]        pkt_open_q;    // per source: a packet has started but not ended

    logic [DWIDTH-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              tid_q;

    logic              out_free;
    logic              gnt_id;
    logic              gnt_valid;
    logic              gnt_last;
    logic [DWIDTH-1:0] gnt_data;
    logic              other_valid;
    logic              accept;
    logic              release_beat;

    // Grant-side muxing, handshake and release decode.
    always_comb begin
        out_free        = ~tvalid_q | m_axis_tready;
        s_axis_tready_0 = (state_q == GRANT0) & out_free;
        s_axis_tready_1 = (state_q == GRANT1) & out_free;
        gnt_id          = (state_q == GRANT1);
        gnt_valid       = gnt_id ? s_axis_tvalid_1 : s_axis_tvalid_0;
        gnt_last        = gnt_id ? s_axis_tlast_1  : s_axis_tlast_0;
        gnt_data        = gnt_id ? s_axis_tdata_1  : s_axis_tdata_0;
        other_valid     = gnt_id ? s_axis_tvalid_0 : s_axis_tvalid_1;
        accept          = (s_axis_tvalid_0 & s_axis_tready_0) |
                          (s_axis_tvalid_1 & s_axis_tready_1);
        release_beat    = accept & (gnt_last | ((BURST_LEN != 0) && (beat_cnt_q == LIM)));
        // Saturate rather than wrap so a long packet never looks like a fresh grant.
        beat_cnt_d      = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CW'(1'b1);
    end

    // Arbitration FSM: grant selection, round-robin pointer, beat counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
            pkt_open_q <= 2'b00;
        end else begin
            if (accept) begin
                pkt_open_q[gnt_id] <= ~gnt_last;
            end
            case (state_q)
                IDLE: begin
                    if (s_axis_tvalid_0 & s_axis_tvalid_1) begin
                        state_q <= rr_ptr_q ? GRANT1 : GRANT0;
                    end else if (s_axis_tvalid_1) begin
                        state_q <= GRANT1;
                    end else if (s_axis_tvalid_0) begin
                        state_q <= GRANT0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (release_beat) begin
                        rr_ptr_q   <= ~gnt_id;
                        beat_cnt_q <= '0;
                        if (other_valid) begin
                            state_q <= gnt_id ? GRANT0 : GRANT1;
                        end else if (gnt_valid) begin
                            state_q <= gnt_id ? GRANT1 : GRANT0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_d;
                    end else if (!gnt_valid && !pkt_open_q[gnt_id]) begin
                        // Grantee has nothing pending at a packet boundary: give the
                        // output back so the other source is not locked out.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register: load on handshake, drain when downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= 1'b0;
        end else if (accept) begin
            tdata_q  <= gnt_data;
            tlast_q  <= gnt_last;
            tid_q    <= gnt_id;
            tvalid_q <= 1'b1;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_out_stream_arbiter.sv
// Directed bench for out_stream_arbiter: instance A (no burst limit) and
// instance B (BURST_LEN=4) driven by per-source beat queues.
module tb_out_stream_arbiter;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } beat_t;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
        logic         tid;
        logic [31:0]  stamp;
    } rx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0][1:0][127:0] s_tdata  = '0;
    logic [1:0][1:0]        s_tvalid = '0;
    logic [1:0][1:0]        s_tlast  = '0;
    wire  [1:0][1:0]        s_tready;
    wire  [1:0][127:0]      m_tdata;
    wire  [1:0]             m_tvalid;
    wire  [1:0]             m_tlast;
    wire  [1:0]             m_tid;
    logic [1:0]             m_tready = 2'b11;
    wire  [1:0]             busy;

    beat_t srcq [2][2][$];
    rx_t   rxq  [2][$];
    bit    hs   [2][2];
    bit    stall[2];
    bit    rnd  [2];
    logic [127:0] hold_d [2];
    logic         hold_l [2];
    logic         hold_t [2];
    logic [31:0]  cyc = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    out_stream_arbiter #(.DWIDTH(128), .BURST_LEN(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata_0(s_tdata[0][0]), .s_axis_tvalid_0(s_tvalid[0][0]),
        .s_axis_tlast_0(s_tlast[0][0]), .s_axis_tready_0(s_tready[0][0]),
        .s_axis_tdata_1(s_tdata[0][1]), .s_axis_tvalid_1(s_tvalid[0][1]),
        .s_axis_tlast_1(s_tlast[0][1]), .s_axis_tready_1(s_tready[0][1]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]),
        .m_axis_tready(m_tready[0]), .busy(busy[0])
    );

    out_stream_arbiter #(.DWIDTH(128), .BURST_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata_0(s_tdata[1][0]), .s_axis_tvalid_0(s_tvalid[1][0]),
        .s_axis_tlast_0(s_tlast[1][0]), .s_axis_tready_0(s_tready[1][0]),
        .s_axis_tdata_1(s_tdata[1][1]), .s_axis_tvalid_1(s_tvalid[1][1]),
        .s_axis_tlast_1(s_tlast[1][1]), .s_axis_tready_1(s_tready[1][1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]),
        .m_axis_tready(m_tready[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source/sink models: drive queue heads on the falling edge, record handshakes
    // just before the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
                if (hs[d][s] && srcq[d][s].size() > 0) void'(srcq[d][s].pop_front());
                if (srcq[d][s].size() > 0) begin
                    s_tvalid[d][s] = 1'b1;
                    s_tdata[d][s]  = srcq[d][s][0].d;
                    s_tlast[d][s]  = srcq[d][s][0].l;
                end else begin
                    s_tvalid[d][s] = 1'b0;
                    s_tdata[d][s]  = '0;
                    s_tlast[d][s]  = 1'b0;
                end
            end
            m_tready[d] = rnd[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (stall[d]) begin
                chk("stall_data", m_tdata[d], hold_d[d]);
                chk("stall_last", m_tlast[d], hold_l[d]);
                chk("stall_tid", m_tid[d], hold_t[d]);
                chk("stall_valid", m_tvalid[d], 1'b1);
            end
            stall[d]  = m_tvalid[d] & ~m_tready[d];
            hold_d[d] = m_tdata[d];
            hold_l[d] = m_tlast[d];
            hold_t[d] = m_tid[d];
            if (m_tvalid[d] & m_tready[d])
                rxq[d].push_back('{d: m_tdata[d], l: m_tlast[d], tid: m_tid[d], stamp: cyc});
            for (int s = 0; s < 2; s++) hs[d][s] = s_tvalid[d][s] & s_tready[d][s];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic push(input int d, input int s, input logic [127:0] data, input logic last);
        srcq[d][s].push_back('{d: data, l: last});
    endtask

    task automatic wait_rx(input int d, input int n, input int budget);
        int k = 0;
        while (rxq[d].size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("rx_timeout", 128'(rxq[d].size() >= n), 128'd1);
    endtask

    task automatic flush();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
                srcq[d][s].delete();
                hs[d][s] = 1'b0;
            end
            rxq[d].delete();
            stall[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        step(2);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_mvalid", m_tvalid[0], 1'b0);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic check_ab(input bit rand_mode);
        logic [127:0] ed[6];
        ed = '{128'hA0, 128'hA1, 128'hA2, 128'hB0, 128'hB1, 128'hB2};
        for (int i = 0; i < 6; i++) begin
            chk("ab_data", rxq[0][i].d, ed[i]);
            chk("ab_tid", rxq[0][i].tid, (i < 3) ? 1'b0 : 1'b1);
            chk("ab_last", rxq[0][i].l, (i == 2 || i == 5) ? 1'b1 : 1'b0);
        end
        if (!rand_mode) begin
            chk("ab_no_bubble", rxq[0][3].stamp, rxq[0][2].stamp + 1);
            chk("ab_back2back", rxq[0][5].stamp, rxq[0][0].stamp + 5);
        end
    endtask

    task automatic load_ab();
        push(0, 0, 128'hA0, 1'b0); push(0, 0, 128'hA1, 1'b0); push(0, 0, 128'hA2, 1'b1);
        push(0, 1, 128'hB0, 1'b0); push(0, 1, 128'hB1, 1'b0); push(0, 1, 128'hB2, 1'b1);
    endtask

    initial begin
        int k;
        // Reset state of both instances.
        step(3);
        for (int d = 0; d < 2; d++) begin
            chk("reset_mvalid", m_tvalid[d], 1'b0);
            chk("reset_mdata", m_tdata[d], 128'h0);
            chk("reset_mlast", m_tlast[d], 1'b0);
            chk("reset_tid", m_tid[d], 1'b0);
            chk("reset_busy", busy[d], 1'b0);
            chk("reset_rdy0", s_tready[d][0], 1'b0);
            chk("reset_rdy1", s_tready[d][1], 1'b0);
        end
        rst_n = 1'b1;
        step(1);

        // 1: single 4-beat packet from src0, exact latency and release to IDLE.
        for (int i = 0; i < 4; i++) push(0, 0, 128'hD0 + 128'(i), (i == 3));
        step(1);
        chk("t1_idle_busy", busy[0], 1'b0);
        step(1);
        chk("t1_grant_busy", busy[0], 1'b1);
        chk("t1_not_yet", m_tvalid[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t1_valid", m_tvalid[0], 1'b1);
            chk("t1_data", m_tdata[0], 128'hD0 + 128'(i));
            chk("t1_last", m_tlast[0], (i == 3) ? 1'b1 : 1'b0);
            chk("t1_tid", m_tid[0], 1'b0);
        end
        step(1);
        chk("t1_end_busy", busy[0], 1'b0);
        chk("t1_end_valid", m_tvalid[0], 1'b0);
        chk("t1_count", 128'(rxq[0].size()), 128'd4);

        // 2: both sources valid from reset, src0 wins, no bubble at the switch.
        do_reset();
        load_ab();
        wait_rx(0, 6, 50);
        step(3);
        chk("t2_count", 128'(rxq[0].size()), 128'd6);
        chk("t2_idle", busy[0], 1'b0);
        if (rxq[0].size() >= 6) check_ab(1'b0);

        // 3: same traffic with random downstream stalls.
        do_reset();
        rnd[0] = 1'b1;
        load_ab();
        wait_rx(0, 6, 200);
        step(5);
        rnd[0] = 1'b0;
        chk("t3_count", 128'(rxq[0].size()), 128'd6);
        if (rxq[0].size() >= 6) check_ab(1'b1);

        // 4: BURST_LEN=4 splits a 10-beat packet around a 2-beat packet.
        for (int i = 0; i < 10; i++) push(1, 0, 128'h100 + 128'(i), (i == 9));
        for (int i = 0; i < 2; i++) push(1, 1, 128'h200 + 128'(i), (i == 1));
        wait_rx(1, 12, 100);
        if (rxq[1].size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                logic [127:0] ed;
                logic         et;
                logic         el;
                if (i < 4) begin
                    ed = 128'h100 + 128'(i); et = 1'b0; el = 1'b0;
                end else if (i < 6) begin
                    ed = 128'h200 + 128'(i - 4); et = 1'b1; el = (i == 5);
                end else begin
                    ed = 128'h100 + 128'(i - 2); et = 1'b0; el = (i == 11);
                end
                chk("t4_data", rxq[1][i].d, ed);
                chk("t4_tid", rxq[1][i].tid, et);
                chk("t4_last", rxq[1][i].l, el);
            end
        end

        // 5: asynchronous reset mid-packet, then src0 wins the first tie.
        flush();
        for (int i = 0; i < 6; i++) push(0, 0, 128'h500 + 128'(i), (i == 5));
        step(4);
        chk("t5_pre_valid", m_tvalid[0], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", m_tvalid[0], 1'b0);
        chk("t5_async_data", m_tdata[0], 128'h0);
        chk("t5_async_last", m_tlast[0], 1'b0);
        chk("t5_async_tid", m_tid[0], 1'b0);
        chk("t5_async_busy", busy[0], 1'b0);
        chk("t5_async_rdy0", s_tready[0][0], 1'b0);
        flush();
        step(2);
        rst_n = 1'b1;
        step(1);
        push(0, 0, 128'h600, 1'b1);
        push(0, 1, 128'h700, 1'b1);
        wait_rx(0, 2, 20);
        if (rxq[0].size() >= 2) begin
            chk("t5_first_tid", rxq[0][0].tid, 1'b0);
            chk("t5_first_data", rxq[0][0].d, 128'h600);
            chk("t5_second_tid", rxq[0][1].tid, 1'b1);
            chk("t5_second_data", rxq[0][1].d, 128'h700);
        end

        // 6: src1 streams single-beat packets, src0 joins later: strict alternation.
        step(2);
        rxq[0].delete();
        for (int i = 0; i < 30; i++) push(0, 1, 128'h400 + 128'(i), 1'b1);
        step(10);
        for (int i = 0; i < 10; i++) push(0, 0, 128'h300 + 128'(i), 1'b1);
        wait_rx(0, 40, 120);
        k = -1;
        for (int i = 0; i < rxq[0].size(); i++) begin
            if (k < 0 && rxq[0][i].tid == 1'b0) k = i;
        end
        chk("t6_src1_first", 128'(k > 0), 128'd1);
        if (k > 0 && rxq[0].size() >= k + 20) begin
            for (int j = 0; j < 20; j++) begin
                chk("t6_alt_tid", rxq[0][k + j].tid, (j % 2 == 0) ? 1'b0 : 1'b1);
                if (j % 2 == 0) chk("t6_src0_data", rxq[0][k + j].d, 128'h300 + 128'(j / 2));
            end
            chk("t6_no_bubble", rxq[0][k + 19].stamp, rxq[0][k].stamp + 19);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
